// File: rtl/snake_engine.sv
// Snake game engine on a 16x16 grid: tracks the snake body, places food and
// decides win/lose. Cells are encoded as {row, col}, and segment 0 is the head.
module snake_engine (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         BtnU,
    input  logic         BtnD,
    input  logic         BtnL,
    input  logic         BtnR,
    input  logic         Tick,
    input  logic [7:0]   Rand,
    output logic         Qi,
    output logic         Qp,
    output logic         Qw,
    output logic         Ql,
    output logic         Qc,
    output logic [7:0]   Food,
    output logic [3:0]   Length,
    output logic [127:0] Locations_Flat
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_PLACE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_WIN   = 3'd3;
    localparam logic [2:0] S_LOSE  = 3'd4;

    // Opposite directions differ only in bit 0, so a reversal is dir ^ 1.
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    logic [2:0] state;
    logic [1:0] dir;
    logic [1:0] last_dir;
    logic [7:0] seg [15];
    logic [3:0] len;
    logic [7:0] food_r;
    logic       qc_r;

    logic [7:0] next_head;
    logic       wall;
    logic       eat;
    logic       self_hit;
    logic       place_hit;
    logic       place_commit;
    logic       tick_play;
    logic       move;
    logic       do_init;
    logic [3:0] new_len;
    logic       btn_any;
    logic [1:0] btn_dir;
    logic [1:0] ref_dir;
    logic       accept;

    always_comb begin
        next_head = seg[0];
        wall      = 1'b0;
        case (dir)
            D_UP: begin
                next_head = seg[0] - 8'd16;
                wall      = (seg[0][7:4] == 4'd0);
            end
            D_DOWN: begin
                next_head = seg[0] + 8'd16;
                wall      = (seg[0][7:4] == 4'd15);
            end
            D_LEFT: begin
                next_head = seg[0] - 8'd1;
                wall      = (seg[0][3:0] == 4'd0);
            end
            default: begin
                next_head = seg[0] + 8'd1;
                wall      = (seg[0][3:0] == 4'd15);
            end
        endcase
    end

    assign eat = (next_head == food_r);

    // The tail vacates its cell on a plain move, so it only blocks when eating.
    always_comb begin
        self_hit  = 1'b0;
        place_hit = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (seg[i] == next_head &&
                ((i < int'(len) - 1) || (i == int'(len) - 1 && eat)))
                self_hit = 1'b1;
            if (seg[i] == Rand && i < int'(len))
                place_hit = 1'b1;
        end
    end

    assign tick_play    = (state == S_PLAY) && Tick;
    assign move         = tick_play && !wall && !self_hit;
    assign place_commit = (state == S_PLACE) && !place_hit;
    assign new_len      = eat ? len + 4'd1 : len;
    assign do_init      = Reset || (state == S_INIT) ||
                          (Start && (state == S_WIN || state == S_LOSE));

    always_comb begin
        btn_any = BtnU | BtnD | BtnL | BtnR;
        if (BtnU)      btn_dir = D_UP;
        else if (BtnD) btn_dir = D_DOWN;
        else if (BtnL) btn_dir = D_LEFT;
        else           btn_dir = D_RIGHT;
    end

    // A move completing this cycle becomes the reference for reversal checks.
    assign ref_dir = tick_play ? dir : last_dir;
    assign accept  = btn_any && (state != S_INIT) && (btn_dir != (ref_dir ^ 2'b01));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT:  if (Start) state <= S_PLACE;
                S_PLACE: if (!place_hit) state <= S_PLAY;
                S_PLAY: begin
                    if (Tick) begin
                        if (wall || self_hit)
                            state <= S_LOSE;
                        else if (eat)
                            state <= (new_len == 4'd15) ? S_WIN : S_PLACE;
                    end
                end
                S_WIN, S_LOSE: if (Start) state <= S_INIT;
                default: state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        qc_r <= !Reset && place_commit;
        if (do_init) begin
            seg[0]   <= 8'h87;
            seg[1]   <= 8'h86;
            seg[2]   <= 8'h85;
            for (int i = 3; i < 15; i++)
                seg[i] <= 8'h00;
            len      <= 4'd3;
            dir      <= D_RIGHT;
            last_dir <= D_RIGHT;
            food_r   <= 8'h00;
        end else begin
            if (accept)
                dir <= btn_dir;
            if (place_commit)
                food_r <= Rand;
            if (move) begin
                last_dir <= dir;
                seg[0]   <= next_head;
                for (int i = 1; i < 15; i++)
                    seg[i] <= (i < int'(new_len)) ? seg[i-1] : 8'h00;
                len      <= new_len;
            end
        end
    end

    always_comb begin
        Locations_Flat = '0;
        for (int i = 0; i < 15; i++)
            Locations_Flat[127-8*i -: 8] = seg[i];
    end

    assign Qi     = (state == S_INIT);
    assign Qp     = (state == S_PLAY) || (state == S_PLACE);
    assign Qw     = (state == S_WIN);
    assign Ql     = (state == S_LOSE);
    assign Qc     = qc_r;
    assign Food   = food_r;
    assign Length = len;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: start/placement, moves, steering, eating,
// wall loss, win at length 15 and reset while placing food.
module tb_snake_engine;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic         BtnU = 1'b0;
    logic         BtnD = 1'b0;
    logic         BtnL = 1'b0;
    logic         BtnR = 1'b0;
    logic         Tick = 1'b0;
    logic [7:0]   Rand = 8'h00;
    logic         Qi, Qp, Qw, Ql, Qc;
    logic [7:0]   Food;
    logic [3:0]   Length;
    logic [127:0] Locations_Flat;

    int vec_count  = 0;
    int miss_count = 0;

    localparam logic [6:0] P_NONE = 7'b0000000;
    localparam logic [6:0] P_RST  = 7'b1000000;
    localparam logic [6:0] P_STA  = 7'b0100000;
    localparam logic [6:0] P_U    = 7'b0010000;
    localparam logic [6:0] P_D    = 7'b0001000;
    localparam logic [6:0] P_L    = 7'b0000100;
    localparam logic [6:0] P_R    = 7'b0000010;
    localparam logic [6:0] P_TK   = 7'b0000001;

    localparam logic [3:0] F_INIT = 4'b1000;
    localparam logic [3:0] F_PLAY = 4'b0100;
    localparam logic [3:0] F_WIN  = 4'b0010;
    localparam logic [3:0] F_LOSE = 4'b0001;

    localparam logic [127:0] INIT_FLAT = {8'h87, 8'h86, 8'h85, 104'h0};

    snake_engine dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .BtnU           (BtnU),
        .BtnD           (BtnD),
        .BtnL           (BtnL),
        .BtnR           (BtnR),
        .Tick           (Tick),
        .Rand           (Rand),
        .Qi             (Qi),
        .Qp             (Qp),
        .Qw             (Qw),
        .Ql             (Ql),
        .Qc             (Qc),
        .Food           (Food),
        .Length         (Length),
        .Locations_Flat (Locations_Flat)
    );

    always #5 Clk = ~Clk;

    // Pulse inputs for exactly one rising edge, then sample 1 ns after it.
    task automatic applyStimulus(input logic [6:0] p, input logic [7:0] r);
        {Reset, Start, BtnU, BtnD, BtnL, BtnR, Tick} = p;
        Rand = r;
        @(posedge Clk);
        #1;
        {Reset, Start, BtnU, BtnD, BtnL, BtnR, Tick} = P_NONE;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {Qi, Qp, Qw, Ql};
    endfunction

    logic [7:0] eat_cells [12] = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D,
                                   8'h8E, 8'h8F, 8'h9F, 8'h9E, 8'h9D, 8'h9C};

    initial begin
        // Reset state and first food placement with one retry
        applyStimulus(P_RST, 8'h00);
        checkOutput("rst_flags", 128'(flags()), 128'(F_INIT));
        checkOutput("rst_len", 128'(Length), 128'(4'd3));
        checkOutput("rst_locs", Locations_Flat, INIT_FLAT);
        checkOutput("rst_food", 128'(Food), 128'(8'h00));
        checkOutput("rst_qc", 128'(Qc), 128'(1'b0));
        applyStimulus(P_STA, 8'h86);
        checkOutput("start_flags", 128'(flags()), 128'(F_PLAY));
        applyStimulus(P_NONE, 8'h86);
        checkOutput("retry_qc", 128'(Qc), 128'(1'b0));
        checkOutput("retry_food", 128'(Food), 128'(8'h00));
        applyStimulus(P_NONE, 8'h40);
        checkOutput("commit_qc", 128'(Qc), 128'(1'b1));
        checkOutput("commit_food", 128'(Food), 128'(8'h40));
        checkOutput("commit_flags", 128'(flags()), 128'(F_PLAY));

        // Plain move right
        applyStimulus(P_TK, 8'h00);
        checkOutput("qc_one_shot", 128'(Qc), 128'(1'b0));
        checkOutput("move_locs", Locations_Flat, {8'h88, 8'h87, 8'h86, 104'h0});
        checkOutput("move_len", 128'(Length), 128'(4'd3));

        // Steering: reversal ignored, U beats D, request with Tick is deferred
        applyStimulus(P_L, 8'h00);
        applyStimulus(P_TK, 8'h00);
        checkOutput("rev_ignored", Locations_Flat, {8'h89, 8'h88, 8'h87, 104'h0});
        applyStimulus(P_U | P_D, 8'h00);
        applyStimulus(P_TK, 8'h00);
        checkOutput("up_priority", Locations_Flat, {8'h79, 8'h89, 8'h88, 104'h0});
        applyStimulus(P_R, 8'h00);
        applyStimulus(P_TK, 8'h00);
        checkOutput("turn_right", Locations_Flat, {8'h7A, 8'h79, 8'h89, 104'h0});
        applyStimulus(P_U | P_TK, 8'h00);
        checkOutput("btn_with_tick", Locations_Flat, {8'h7B, 8'h7A, 8'h79, 104'h0});
        applyStimulus(P_TK, 8'h00);
        checkOutput("deferred_up", Locations_Flat, {8'h6B, 8'h7B, 8'h7A, 104'h0});

        // Eat from the start position: grow and keep the old tail
        applyStimulus(P_RST, 8'h00);
        applyStimulus(P_STA, 8'h00);
        applyStimulus(P_NONE, 8'h88);
        checkOutput("food_88", 128'(Food), 128'(8'h88));
        applyStimulus(P_TK, 8'h00);
        checkOutput("eat_len", 128'(Length), 128'(4'd4));
        checkOutput("eat_locs", Locations_Flat, {8'h88, 8'h87, 8'h86, 8'h85, 96'h0});
        checkOutput("eat_flags", 128'(flags()), 128'(F_PLAY));
        applyStimulus(P_NONE, 8'h88);
        checkOutput("body_retry_qc", 128'(Qc), 128'(1'b0));
        applyStimulus(P_NONE, 8'h20);
        checkOutput("food_20", 128'(Food), 128'(8'h20));

        // Walk into the top-right corner and hit the right wall
        applyStimulus(P_U, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(P_TK, 8'h00);
        checkOutput("top_row", Locations_Flat, {8'h08, 8'h18, 8'h28, 8'h38, 96'h0});
        applyStimulus(P_R, 8'h00);
        for (int i = 0; i < 7; i++) applyStimulus(P_TK, 8'h00);
        checkOutput("corner", Locations_Flat, {8'h0F, 8'h0E, 8'h0D, 8'h0C, 96'h0});
        checkOutput("corner_flags", 128'(flags()), 128'(F_PLAY));
        applyStimulus(P_TK, 8'h00);
        checkOutput("wall_flags", 128'(flags()), 128'(F_LOSE));
        checkOutput("wall_frozen", Locations_Flat, {8'h0F, 8'h0E, 8'h0D, 8'h0C, 96'h0});
        checkOutput("wall_len", 128'(Length), 128'(4'd4));
        applyStimulus(P_L | P_TK, 8'h00);
        checkOutput("lose_tick_ign", Locations_Flat, {8'h0F, 8'h0E, 8'h0D, 8'h0C, 96'h0});
        checkOutput("lose_stays", 128'(flags()), 128'(F_LOSE));
        applyStimulus(P_STA, 8'h00);
        checkOutput("lose_restart", 128'(flags()), 128'(F_INIT));
        checkOutput("lose_restart_locs", Locations_Flat, INIT_FLAT);

        // Grow from 3 to 15 by always placing food directly ahead
        applyStimulus(P_STA, 8'h00);
        for (int k = 0; k < 12; k++) begin
            logic [6:0] btn;
            btn = (eat_cells[k] == 8'h9F) ? P_D : (eat_cells[k] == 8'h9E) ? P_L : P_NONE;
            applyStimulus(btn, eat_cells[k]);
            checkOutput($sformatf("grow_qc_%0d", k), 128'(Qc), 128'(1'b1));
            applyStimulus(P_TK, 8'h00);
            checkOutput($sformatf("grow_len_%0d", k), 128'(Length), 128'(4 + k));
        end
        checkOutput("win_flags", 128'(flags()), 128'(F_WIN));
        checkOutput("win_locs", Locations_Flat,
                    {8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'h8F, 8'h8E, 8'h8D, 8'h8C,
                     8'h8B, 8'h8A, 8'h89, 8'h88, 8'h87, 8'h86, 8'h85, 8'h00});
        applyStimulus(P_TK, 8'h00);
        checkOutput("win_tick_ign", 128'(Length), 128'(4'd15));

        // Reset in the middle of placement wins over Start, Tick and buttons
        applyStimulus(P_STA, 8'h00);
        checkOutput("win_restart", 128'(flags()), 128'(F_INIT));
        applyStimulus(P_STA, 8'h00);
        applyStimulus(P_NONE, 8'h88);
        applyStimulus(P_TK, 8'h00);
        applyStimulus(P_NONE, 8'h87);
        checkOutput("mid_place", 128'(flags()), 128'(F_PLAY));
        applyStimulus(P_RST | P_STA | P_TK | P_U, 8'h50);
        checkOutput("midrst_flags", 128'(flags()), 128'(F_INIT));
        checkOutput("midrst_locs", Locations_Flat, INIT_FLAT);
        checkOutput("midrst_len", 128'(Length), 128'(4'd3));
        checkOutput("midrst_food", 128'(Food), 128'(8'h00));
        checkOutput("midrst_qc", 128'(Qc), 128'(1'b0));
        applyStimulus(P_STA, 8'h00);
        applyStimulus(P_NONE, 8'h40);
        applyStimulus(P_TK, 8'h00);
        checkOutput("midrst_dir", Locations_Flat, {8'h88, 8'h87, 8'h86, 104'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
